// File: rtl/eth_gen_pkg.sv
// Shared types and constants for the MII/GMII receive frame generator.
// States, framing bytes, length limits and CRC-32 constants.
package eth_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HDR,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int PREAMBLE_BYTES = 7;
  localparam int MIN_PAYLOAD    = 46;
  localparam int MAX_PAYLOAD    = 1500;
  localparam int HDR_BYTES      = 14;
  localparam int FCS_BYTES      = 4;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  function automatic logic [15:0] clamp_len(
    input logic [15:0] len
  );
    return (len > 16'(MAX_PAYLOAD)) ?
      16'(MAX_PAYLOAD) : len;
  endfunction

endpackage

// File: rtl/mii_frame_gen_if.sv
// Request and PHY-side signals of the frame generator.
// master drives requests; slave is the generator itself.
interface mii_frame_gen_if #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [47:0]       dst_mac;
  logic [47:0]       src_mac;
  logic [15:0]       eth_type;
  logic [15:0]       payload_len;
  logic [7:0]        seed;
  logic              err_inject;
  logic              phy_rx_dv;
  logic [DATA_W-1:0] phy_rxd;
  logic              phy_rx_er;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output start, dst_mac, src_mac, eth_type,
    output payload_len, seed, err_inject,
    input  phy_rx_dv, phy_rxd, phy_rx_er,
    input  busy, done, frame_cnt
  );

  modport slave (
    input  start, dst_mac, src_mac, eth_type,
    input  payload_len, seed, err_inject,
    output phy_rx_dv, phy_rxd, phy_rx_er,
    output busy, done, frame_cnt
  );
endinterface

// File: rtl/crc32_d8.sv
// One-byte update of the reflected IEEE CRC-32 register.
// Purely combinational; data is consumed LSB first.
module crc32_d8
  import eth_gen_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i])
        crc_out = (crc_out >> 1) ^ CRC_POLY_REFL;
      else
        crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/mii_frame_gen.sv
// MII/GMII receive frame generator (preamble..pad, FCS, IFG).
// FCS append enabled by defining MII_FRAME_GEN_FCS_EN.
module mii_frame_gen
  import eth_gen_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 16
) (
  input logic           clk,
  input logic           reset,
  mii_frame_gen_if.slave bus
);

`ifdef MII_FRAME_GEN_FCS_EN
  localparam state_t DATA_END = ST_FCS;
`else
  localparam state_t DATA_END = ST_IFG;
`endif

  state_t            state;
  state_t            nxt;
  logic [15:0]       idx;
  logic [15:0]       eff_len;
  logic [15:0]       pad_len;
  logic [111:0]      hdr;
  logic [7:0]        seed_q;
  logic              err_q;
  logic              dv_q;
  logic [DATA_W-1:0] rxd_q;
  logic              er_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              byte_last;
  logic              at_end;
  logic              in_frame;
  logic [7:0]        cur_byte;
  logic [DATA_W-1:0] beat;
  logic [15:0]       len_c;
  logic [15:0]       pad_c;

`ifdef MII_FRAME_GEN_FCS_EN
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
`endif

  assign len_c = clamp_len(bus.payload_len);
  assign pad_c = (len_c >= 16'(MIN_PAYLOAD)) ?
    16'd0 : 16'(MIN_PAYLOAD) - len_c;

  assign in_frame = (state != ST_IDLE) &&
                    (state != ST_IFG);

  // Nibble mode: every byte spans two beats, low nibble first.
  generate
    if (DATA_W == 4) begin : g_mii
      logic nib;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          nib <= 1'b0;
        else if (state == ST_IDLE)
          nib <= 1'b0;
        else
          nib <= ~nib;
      end
      assign byte_last = nib;
      assign beat = nib ? cur_byte[7:4] : cur_byte[3:0];
    end else begin : g_gmii
      assign byte_last = 1'b1;
      assign beat = cur_byte;
    end
  endgenerate

  always_comb begin
    cur_byte = 8'h00;
    at_end   = 1'b0;
    nxt      = state;
    unique case (state)
      ST_PREAMBLE: begin
        cur_byte = PREAMBLE_BYTE;
        at_end   = idx == 16'(PREAMBLE_BYTES - 1);
        nxt      = ST_SFD;
      end
      ST_SFD: begin
        cur_byte = SFD_BYTE;
        at_end   = 1'b1;
        nxt      = ST_HDR;
      end
      ST_HDR: begin
        cur_byte = hdr[111:104];
        at_end   = idx == 16'(HDR_BYTES - 1);
        nxt      = (eff_len == 16'd0) ? ST_PAD : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        cur_byte = seed_q + idx[7:0];
        at_end   = idx == eff_len - 16'd1;
        nxt      = (pad_len != 16'd0) ? ST_PAD : DATA_END;
      end
      ST_PAD: begin
        at_end = idx == pad_len - 16'd1;
        nxt    = DATA_END;
      end
`ifdef MII_FRAME_GEN_FCS_EN
      ST_FCS: begin
        cur_byte = ~crc_q[7:0];
        at_end   = idx == 16'(FCS_BYTES - 1);
        nxt      = ST_IFG;
      end
`endif
      ST_IFG: begin
        at_end = idx == 16'(IFG_BYTES - 1);
        nxt    = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      eff_len <= '0;
      pad_len <= '0;
      hdr     <= '0;
      seed_q  <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      rxd_q   <= '0;
      er_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      dv_q   <= in_frame;
      rxd_q  <= beat;
      er_q   <= err_q && (state == ST_PAYLOAD) &&
                (idx == 16'd0);
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        busy_q <= bus.start;
        if (bus.start) begin
          state   <= ST_PREAMBLE;
          idx     <= '0;
          eff_len <= len_c;
          pad_len <= pad_c;
          hdr     <= {bus.dst_mac, bus.src_mac, bus.eth_type};
          seed_q  <= bus.seed;
          err_q   <= bus.err_inject;
        end
      end else if (byte_last) begin
        if (state == ST_HDR)
          hdr <= {hdr[103:0], 8'h00};
        if (at_end) begin
          idx   <= '0;
          state <= nxt;
        end else begin
          idx <= idx + 16'd1;
        end
        if (state == ST_IFG && at_end) begin
          done_q <= 1'b1;
          cnt_q  <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef MII_FRAME_GEN_FCS_EN
  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (cur_byte),
    .crc_out (crc_nxt)
  );

  // FCS bytes are taken from the low end, so shift after each one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc_q <= CRC_INIT;
    else if (state == ST_IDLE && bus.start)
      crc_q <= CRC_INIT;
    else if (byte_last && (state == ST_HDR ||
             state == ST_PAYLOAD || state == ST_PAD))
      crc_q <= crc_nxt;
    else if (byte_last && state == ST_FCS)
      crc_q <= {8'h00, crc_q[31:8]};
  end
`endif

  assign bus.phy_rx_dv = dv_q;
  assign bus.phy_rxd   = rxd_q;
  assign bus.phy_rx_er = er_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.frame_cnt = cnt_q;

endmodule
